// File: rtl/test_top_nn_pkg.sv
// Shared constants, weight/bias tables and the ReLU/saturation helper for the NN-PLL
// fully-connected layer.
package test_top_nn_pkg;

    localparam int N_IN  = 12;
    localparam int N_OUT = 10;
    localparam int IN_W  = 6;
    localparam int OUT_W = 8;
    localparam int ACC_W = 14;

    typedef logic signed [2:0]       weight_t;
    typedef logic signed [ACC_W-1:0] acc_t;

    // Weight ROM: W[j][i] = ((i + 2*j) mod 7) - 3, always within -3..+3
    function automatic weight_t weight(input int j, input int i);
        int v;
        v = ((i + (2 * j)) % 7) - 3;
        return weight_t'(v);
    endfunction

    function automatic acc_t bias(input int j);
        return acc_t'(j);
    endfunction

    function automatic logic [OUT_W-1:0] relu_sat(input acc_t acc, input int shift);
        acc_t s;
        s = acc >>> shift;
        if (s < 14'sd0) begin
            return 8'd0;
        end else if (s > 14'sd255) begin
            return 8'd255;
        end else begin
            return s[OUT_W-1:0];
        end
    endfunction

endpackage

// File: rtl/test_top_nn_neuron.sv
// One combinational neuron: 12 unsigned features dotted with 12 signed weights,
// plus bias, then shifted and clamped to an unsigned 8-bit activation.
module nn_neuron
    import test_top_nn_pkg::*;
#(
    parameter int SHIFT = 0
) (
    input  logic [N_IN-1:0][IN_W-1:0] x,
    input  weight_t [N_IN-1:0]        w,
    input  acc_t                      b,
    output logic [OUT_W-1:0]          y
);

    acc_t prod_s [N_IN];
    acc_t acc_s;

    // Features are zero-extended and weights sign-extended so the product stays signed
    for (genvar i = 0; i < N_IN; i++) begin : g_prod
        acc_t xe_s;
        acc_t we_s;
        assign xe_s      = acc_t'({{(ACC_W-IN_W){1'b0}}, x[i]});
        assign we_s      = acc_t'({{(ACC_W-3){w[i][2]}}, w[i]});
        assign prod_s[i] = xe_s * we_s;
    end

    // Accumulate products on top of the bias
    always_comb begin
        acc_s = b;
        for (int i = 0; i < N_IN; i++) begin
            acc_s = acc_s + prod_s[i];
        end
    end

    assign y = relu_sat(acc_s, SHIFT);

endmodule

// File: rtl/test_top_nn.sv
// Fully-connected 12->10 layer with constant weights, ReLU/saturation and a
// one-cycle registered output. Define NN_BIAS_EN to add bias B[j] = j per neuron.
module test_top_nn
    import test_top_nn_pkg::*;
#(
    parameter int SHIFT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in1,
    input  logic [IN_W-1:0]  in2,
    input  logic [IN_W-1:0]  in3,
    input  logic [IN_W-1:0]  in4,
    input  logic [IN_W-1:0]  in5,
    input  logic [IN_W-1:0]  in6,
    input  logic [IN_W-1:0]  in7,
    input  logic [IN_W-1:0]  in8,
    input  logic [IN_W-1:0]  in9,
    input  logic [IN_W-1:0]  in10,
    input  logic [IN_W-1:0]  in11,
    input  logic [IN_W-1:0]  in12,
    output logic             out_valid,
    output logic [OUT_W-1:0] out1,
    output logic [OUT_W-1:0] out2,
    output logic [OUT_W-1:0] out3,
    output logic [OUT_W-1:0] out4,
    output logic [OUT_W-1:0] out5,
    output logic [OUT_W-1:0] out6,
    output logic [OUT_W-1:0] out7,
    output logic [OUT_W-1:0] out8,
    output logic [OUT_W-1:0] out9,
    output logic [OUT_W-1:0] out10
);

    logic [N_IN-1:0][IN_W-1:0]   x_s;
    logic [N_OUT-1:0][OUT_W-1:0] y_s;
    logic [N_OUT-1:0][OUT_W-1:0] y_r;
    logic                        valid_r;

    assign x_s = {in12, in11, in10, in9, in8, in7, in6, in5, in4, in3, in2, in1};

    for (genvar j = 0; j < N_OUT; j++) begin : g_neuron
        weight_t [N_IN-1:0] w_s;
        acc_t               b_s;

        for (genvar i = 0; i < N_IN; i++) begin : g_w
            assign w_s[i] = weight(j, i);
        end

`ifdef NN_BIAS_EN
        assign b_s = bias(j);
`else
        assign b_s = '0;
`endif

        nn_neuron #(.SHIFT(SHIFT)) u_neuron (
            .x (x_s),
            .w (w_s),
            .b (b_s),
            .y (y_s[j])
        );
    end

    // Output register: reset clears everything, idle cycles hold the last activations
    always_ff @(posedge clk) begin
        if (rst) begin
            y_r     <= '0;
            valid_r <= 1'b0;
        end else if (in_valid) begin
            y_r     <= y_s;
            valid_r <= 1'b1;
        end else begin
            valid_r <= 1'b0;
        end
    end

    assign out_valid = valid_r;
    assign out1      = y_r[0];
    assign out2      = y_r[1];
    assign out3      = y_r[2];
    assign out4      = y_r[3];
    assign out5      = y_r[4];
    assign out6      = y_r[5];
    assign out7      = y_r[6];
    assign out8      = y_r[7];
    assign out9      = y_r[8];
    assign out10     = y_r[9];

endmodule

// File: tb/tb_test_top_nn.sv
// Scoreboard bench for test_top_nn: two instances (SHIFT=0 and SHIFT=2) share the
// stimulus; hand-computed accumulator tables give the expected activations.
module tb_test_top_nn;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [5:0] x [12];
    logic [7:0] ya [10];
    logic [7:0] yb [10];
    logic       va;
    logic       vb;

    always #5 clk = ~clk;

    test_top_nn #(.SHIFT(0)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .in1(x[0]), .in2(x[1]), .in3(x[2]), .in4(x[3]), .in5(x[4]), .in6(x[5]),
        .in7(x[6]), .in8(x[7]), .in9(x[8]), .in10(x[9]), .in11(x[10]), .in12(x[11]),
        .out_valid(va),
        .out1(ya[0]), .out2(ya[1]), .out3(ya[2]), .out4(ya[3]), .out5(ya[4]),
        .out6(ya[5]), .out7(ya[6]), .out8(ya[7]), .out9(ya[8]), .out10(ya[9])
    );

    test_top_nn #(.SHIFT(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .in1(x[0]), .in2(x[1]), .in3(x[2]), .in4(x[3]), .in5(x[4]), .in6(x[5]),
        .in7(x[6]), .in8(x[7]), .in9(x[8]), .in10(x[9]), .in11(x[10]), .in12(x[11]),
        .out_valid(vb),
        .out1(yb[0]), .out2(yb[1]), .out3(yb[2]), .out4(yb[3]), .out5(yb[4]),
        .out6(yb[5]), .out7(yb[6]), .out8(yb[7]), .out9(yb[8]), .out10(yb[9])
    );

    // Vectors: 0 all zero, 1 in1=63, 2 in1=in8=63, 3 all 63, 4 in2=10
    logic [5:0] vin_tab [5][12] = '{
        '{6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  6'd0},
        '{6'd63, 6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  6'd0},
        '{6'd63, 6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  6'd63, 6'd0,  6'd0,  6'd0,  6'd0},
        '{6'd63, 6'd63, 6'd63, 6'd63, 6'd63, 6'd63, 6'd63, 6'd63, 6'd63, 6'd63, 6'd63, 6'd63},
        '{6'd0,  6'd10, 6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  6'd0}
    };

    // Dot products (no bias) worked out by hand from W[j][i] = ((i+2j) mod 7) - 3
    int acc_tab [5][10] = '{
        '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
        '{-189, -63, 63, 189, -126, 0, 126, -189, -63, 63},
        '{-378, -126, 126, 378, -252, 0, 252, -378, -126, 126},
        '{-315, 315, 63, -189, 0, 189, -63, -315, 315, 63},
        '{-20, 0, 20, -30, -10, 10, 30, -20, 0, 20}
    };

    typedef struct packed {
        logic [9:0][7:0] a;
        logic [9:0][7:0] b;
    } exp_t;

    exp_t q [$];
    exp_t held;
    int   cur_vec;
    bit   checking;
    int   checks;
    int   errors;

    function automatic logic [7:0] ref_y(input int acc, input int sh);
        int s;
        s = acc >>> sh;
        if (s < 0) return 8'd0;
        else if (s > 255) return 8'd255;
        else return s[7:0];
    endfunction

    // Stimulus side: every accepted sample pushes its expected response
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            held = '0;
        end else if (in_valid) begin
            exp_t e;
            for (int j = 0; j < 10; j++) begin
                int b;
                b = 0;
`ifdef NN_BIAS_EN
                b = j;
`endif
                e.a[j] = ref_y(acc_tab[cur_vec][j] + b, 0);
                e.b[j] = ref_y(acc_tab[cur_vec][j] + b, 2);
            end
            q.push_back(e);
            held = e;
        end
    end

    task automatic cmp_outs(input exp_t e, input string tag);
        for (int j = 0; j < 10; j++) begin
            checks++;
            if (ya[j] !== e.a[j]) begin
                errors++;
                $display("FAIL %s shift0 out%0d: got %0d expected %0d", tag, j + 1, ya[j], e.a[j]);
            end
            checks++;
            if (yb[j] !== e.b[j]) begin
                errors++;
                $display("FAIL %s shift2 out%0d: got %0d expected %0d", tag, j + 1, yb[j], e.b[j]);
            end
        end
    endtask

    // Monitor: pops on out_valid, otherwise outputs must hold their last value
    always @(negedge clk) begin
        if (checking) begin
            checks++;
            if (vb !== va) begin
                errors++;
                $display("FAIL valid_match: shift2 valid %0b shift0 valid %0b", vb, va);
            end
            if (va === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid: got out_valid=1 expected 0");
                end else begin
                    cmp_outs(q.pop_front(), "sample");
                end
            end else begin
                checks++;
                if (q.size() != 0) begin
                    errors++;
                    $display("FAIL missing_valid: got out_valid=%0b expected 1", va);
                    q.delete();
                end
                cmp_outs(held, "hold");
            end
        end
    end

    task automatic send(input int v);
        @(negedge clk);
        rst      = 1'b0;
        x        = vin_tab[v];
        cur_vec  = v;
        in_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rst      = 1'b0;
            in_valid = 1'b0;
            x        = vin_tab[3];
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        checking = 1'b0;
        held     = '0;
        cur_vec  = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        x        = vin_tab[0];
        repeat (2) @(posedge clk);
        @(negedge clk);
        checking = 1'b1;
        idle(2);
        send(0);
        idle(1);
        send(1);
        idle(2);
        send(2);
        send(3);
        send(4);
        send(1);
        send(3);
        // reset collides with a valid sample: that sample must be dropped
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        x        = vin_tab[2];
        cur_vec  = 2;
        send(4);
        send(2);
        idle(3);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
